// File: rtl/shift_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_latch_pkg
// Description : Shared constants for the shift_latch_reg block: shift-stage
//               mode encodings and the default key debounce count.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_latch_pkg;

    // Shift-stage operating modes, sampled only in the shift-pulse cycle
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // 10 ms of stable key level at a 50 MHz system clock
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage : shift_latch_pkg
`default_nettype wire

// File: rtl/key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen
// Description : Turns a raw, asynchronous, bouncy push-button into a single
//               clean one-cycle strobe on each press.
//               Path: 2-FF synchroniser -> (optional) debounce counter ->
//               registered rising-edge detector.
//               Build option: SHIFT_LATCH_DEBOUNCE_EN
//                 defined   : level must be stable DEBOUNCE_CYCLES samples,
//                             press-to-pulse latency 2 + DEBOUNCE_CYCLES + 1
//                 undefined : synchroniser + edge detector only, latency 3
// Ports       : clk       - system clock
//               rst       - synchronous active-high reset
//               key       - raw key level, active-high when pressed
//               key_pulse - one-cycle strobe per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module key_pulse_gen
    import shift_latch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_pulse
);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
            $error("key_pulse_gen: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic       sync1;
    logic       sync2;
    logic [1:0] fill;      // marks when sync2 reflects a real post-reset sample
    logic       armed;     // set once the key has been seen released after reset
    logic       level;     // accepted key level
    logic       level_d;

    // Synchroniser plus arming. A key held through reset must not produce a
    // pulse, so the edge detector is gated until the synchronised key has
    // been observed low. The fill pipe keeps the reset-cleared synchroniser
    // contents from counting as a genuine "released" observation.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && !sync2) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef SHIFT_LATCH_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             stable;

    // Count consecutive samples that disagree with the accepted level; any
    // sample that agrees again (a bounce) restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = stable;
`else
    assign level = sync2;
`endif

    // Registered rising-edge detector; releases never produce a strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d   <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            level_d   <= level;
            key_pulse <= armed & level & ~level_d;
        end
    end

endmodule : key_pulse_gen
`default_nettype wire

// File: rtl/shift_latch_reg.sv
`default_nettype none
// ============================================================================
// Module      : shift_latch_reg
// Description : Parametrised 74HC595-style register: a shift stage clocked by
//               a debounced SH key and a storage latch clocked by a debounced
//               ST key, with hold / shift-left / shift-right / parallel-load
//               modes, active-low output enable and a serial cascade output.
//               Build option: SHIFT_LATCH_DEBOUNCE_EN (key debounce enable,
//               see key_pulse_gen).
// Ports       : clk        - system clock, all state on posedge
//               rst        - synchronous active-high reset
//               ds         - serial data in
//               sh_key     - raw shift-clock key
//               st_key     - raw storage-clock key
//               oe_n       - output enable, active-low (1 blanks q to ones)
//               mode       - 00 hold, 01 shl, 10 shr, 11 load
//               pdata      - parallel load data
//               q          - storage stage or all-ones when blanked
//               q_serial   - cascade output, last bit shifted out
//               sh_pulse_o - one-cycle debounced shift strobe
// Revision    : 1.0 - initial release
// ============================================================================
module shift_latch_reg
    import shift_latch_pkg::*;
#(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] INIT_VAL        = {WIDTH{1'b1}},
    parameter bit               INVERT_DS       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ds,
    input  logic             sh_key,
    input  logic             st_key,
    input  logic             oe_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             q_serial,
    output logic             sh_pulse_o
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("shift_latch_reg: WIDTH must be at least 2");
        end
    endgenerate

    logic             sh_pulse;
    logic             st_pulse;
    logic             d_in;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] store_r;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sh_key (
        .clk       (clk),
        .rst       (rst),
        .key       (sh_key),
        .key_pulse (sh_pulse)
    );

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_st_key (
        .clk       (clk),
        .rst       (rst),
        .key       (st_key),
        .key_pulse (st_pulse)
    );

    assign d_in = ds ^ INVERT_DS;

    // Storage captures the pre-update shift value, so coincident ST and SH
    // pulses behave like the 595 with ST ahead of SH.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r  <= INIT_VAL;
            store_r  <= INIT_VAL;
            q_serial <= 1'b1;
        end else begin
            if (st_pulse) begin
                store_r <= shift_r;
            end
            if (sh_pulse) begin
                case (mode)
                    MODE_HOLD: begin
                        shift_r <= shift_r;
                    end
                    MODE_SHL: begin
                        shift_r  <= {shift_r[WIDTH-2:0], d_in};
                        q_serial <= shift_r[WIDTH-1];
                    end
                    MODE_SHR: begin
                        shift_r  <= {d_in, shift_r[WIDTH-1:1]};
                        q_serial <= shift_r[0];
                    end
                    MODE_LOAD: begin
                        shift_r <= pdata;
                    end
                    default: begin
                        shift_r <= shift_r;
                    end
                endcase
            end
        end
    end

    // Blanking is combinational so oe_n acts in the same cycle; store_r keeps
    // updating underneath.
    assign q          = oe_n ? {WIDTH{1'b1}} : store_r;
    assign sh_pulse_o = sh_pulse;

endmodule : shift_latch_reg
`default_nettype wire

// File: tb/tb_shift_latch_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_latch_reg
// Description : Self-checking bench for shift_latch_reg (WIDTH=8,
//               DEBOUNCE_CYCLES=4, INVERT_DS=0) against a behavioural model.
//               Expected key latency follows SHIFT_LATCH_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_latch_reg;

    localparam int DEB = 4;
`ifdef SHIFT_LATCH_DEBOUNCE_EN
    localparam int LAT        = 2 + DEB + 1;
    localparam int EXP_BOUNCE = 1;
`else
    localparam int LAT        = 3;
    localparam int EXP_BOUNCE = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ds = 1'b0;
    logic       sh_key = 1'b0;
    logic       st_key = 1'b0;
    logic       oe_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] pdata = 8'h00;
    logic [7:0] q;
    logic       q_serial;
    logic       sh_pulse_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the visible state
    logic [7:0] m_shift;
    logic [7:0] m_store;
    logic       m_qs;

    always #5 clk = ~clk;

    shift_latch_reg #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEB),
        .INIT_VAL        (8'hFF),
        .INVERT_DS       (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ds         (ds),
        .sh_key     (sh_key),
        .st_key     (st_key),
        .oe_n       (oe_n),
        .mode       (mode),
        .pdata      (pdata),
        .q          (q),
        .q_serial   (q_serial),
        .sh_pulse_o (sh_pulse_o)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_shift = 8'hFF;
        m_store = 8'hFF;
        m_qs    = 1'b1;
    endtask

    // Storage sees the shift value from before the shift in the same cycle
    task automatic model_apply(input bit sh, input bit st);
        int s;
        int d;
        s = int'(m_shift);
        d = int'(ds);
        if (st) m_store = m_shift;
        if (sh) begin
            case (mode)
                2'd1: begin m_qs = (s / 128) != 0; m_shift = 8'(((s * 2) % 256) + d); end
                2'd2: begin m_qs = (s % 2) != 0;   m_shift = 8'((s / 2) + d * 128); end
                2'd3: m_shift = pdata;
                default: ;
            endcase
        end
    endtask

    // Press the selected keys, hold long enough for a pulse, release and let
    // the release settle. Reports first-pulse latency and total pulses seen.
    task automatic press(input bit do_sh, input bit do_st, output int lat, output int npulses);
        sh_key  = do_sh;
        st_key  = do_st;
        lat     = -1;
        npulses = 0;
        for (int i = 1; i <= LAT + 4; i++) begin
            step();
            if (sh_pulse_o) begin
                npulses++;
                if (lat < 0) lat = i;
            end
        end
        sh_key = 1'b0;
        st_key = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (sh_pulse_o) npulses++;
        end
        model_apply(do_sh, do_st);
    endtask

    task automatic test_reset();
        @(negedge clk);
        oe_n = 1'b1;
        rst  = 1'b1;
        step();
        total++; if (sh_pulse_o !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", sh_pulse_o); end
        rst = 1'b0;
        step();
        model_reset();
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL reset_q_blank: got %h want ff", q); end
        oe_n = 1'b0;
        #1;
        total++; if (q !== m_store) begin bad++; $display("FAIL reset_q: got %h want %h", q, m_store); end
        total++; if (q_serial !== 1'b1) begin bad++; $display("FAIL reset_qs: got %b want 1", q_serial); end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_shift_left();
        int lat;
        int np;
        logic [2:0] bits;
        bits = 3'b010;
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            ds = bits[2 - i];
            press(1'b1, 1'b0, lat, np);
            total++; if (lat !== LAT || np !== 1) begin bad++; $display("FAIL shl_latency: got lat=%0d n=%0d want lat=%0d n=1", lat, np, LAT); end
            total++; if (q_serial !== 1'b1) begin bad++; $display("FAIL shl_qs: got %b want 1", q_serial); end
        end
        press(1'b0, 1'b1, lat, np);
        total++; if (q !== 8'hFA || q !== m_store) begin bad++; $display("FAIL shl_q: got %h want fa (model %h)", q, m_store); end
    endtask

    task automatic test_debounce();
        int cnt;
        int last;
        logic [7:0] q_before;
        logic       qs_before;
        cnt       = 0;
        last      = -1;
        q_before  = q;
        qs_before = q_serial;
        mode      = 2'b00;
        for (int i = 0; i < 4; i++) begin
            sh_key = (i % 2 == 0);
            step();
            if (sh_pulse_o) cnt++;
        end
        sh_key = 1'b1;
        for (int i = 1; i <= LAT + 4; i++) begin
            step();
            if (sh_pulse_o) begin cnt++; last = i; end
        end
        total++; if (cnt !== EXP_BOUNCE) begin bad++; $display("FAIL bounce_count: got %0d want %0d", cnt, EXP_BOUNCE); end
        total++; if (last !== LAT) begin bad++; $display("FAIL bounce_latency: got %0d want %0d", last, LAT); end
        sh_key = 1'b0;
        cnt = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            step();
            if (sh_pulse_o) cnt++;
        end
        total++; if (cnt !== 0) begin bad++; $display("FAIL release_pulse: got %0d want 0", cnt); end
        total++; if (q !== q_before || q_serial !== qs_before) begin bad++; $display("FAIL hold_state: got %h/%b want %h/%b", q, q_serial, q_before, qs_before); end
    endtask

    task automatic test_load_shr();
        int lat;
        int np;
        mode  = 2'b11;
        pdata = 8'hA5;
        press(1'b1, 1'b0, lat, np);
        mode  = 2'b10;
        pdata = 8'h00;
        ds    = 1'b1;
        press(1'b1, 1'b0, lat, np);
        press(1'b0, 1'b1, lat, np);
        total++; if (q !== 8'hD2 || q !== m_store) begin bad++; $display("FAIL shr_q: got %h want d2 (model %h)", q, m_store); end
        total++; if (q_serial !== 1'b1) begin bad++; $display("FAIL shr_qs: got %b want 1", q_serial); end
    endtask

    task automatic test_simultaneous();
        int lat;
        int np;
        mode  = 2'b11;
        pdata = 8'h0F;
        press(1'b1, 1'b0, lat, np);
        mode = 2'b01;
        ds   = 1'b1;
        press(1'b1, 1'b1, lat, np);
        total++; if (q !== 8'h0F) begin bad++; $display("FAIL simul_store: got %h want 0f", q); end
        mode = 2'b00;
        press(1'b0, 1'b1, lat, np);
        total++; if (q !== 8'h1F || m_store !== 8'h1F) begin bad++; $display("FAIL simul_shift: got %h want 1f (model %h)", q, m_store); end
    endtask

    task automatic test_oe();
        int lat;
        int np;
        oe_n = 1'b1;
        #1;
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL oe_blank: got %h want ff", q); end
        mode  = 2'b11;
        pdata = 8'h3C;
        press(1'b1, 1'b1, lat, np);
        press(1'b0, 1'b1, lat, np);
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL oe_still_blank: got %h want ff", q); end
        oe_n = 1'b0;
        #1;
        total++; if (q !== m_store || m_store !== 8'h3C) begin bad++; $display("FAIL oe_release: got %h want 3c (model %h)", q, m_store); end
    endtask

    task automatic test_random();
        int lat;
        int np;
        bit sh;
        bit st;
        for (int it = 0; it < 30; it++) begin
            mode  = 2'($urandom_range(0, 3));
            ds    = 1'($urandom);
            pdata = 8'($urandom);
            sh    = 1'($urandom);
            st    = 1'($urandom);
            if (!sh && !st) sh = 1'b1;
            press(sh, st, lat, np);
            total++; if (np !== int'(sh)) begin bad++; $display("FAIL rand_pulses[%0d]: got %0d want %0d", it, np, sh); end
            // Inputs wander between strobes and must be ignored
            mode  = 2'($urandom);
            pdata = 8'($urandom);
            ds    = 1'($urandom);
            for (int i = 0; i < 3; i++) step();
            total++; if (q !== m_store || q_serial !== m_qs) begin bad++; $display("FAIL rand_state[%0d]: got %h/%b want %h/%b", it, q, q_serial, m_store, m_qs); end
        end
        // Flush the model shift stage into storage to compare it too
        mode = 2'b00;
        press(1'b0, 1'b1, lat, np);
        total++; if (q !== m_store) begin bad++; $display("FAIL rand_flush: got %h want %h", q, m_store); end
    endtask

    task automatic test_mid_reset();
        int cnt;
        int lat;
        int np;
        cnt    = 0;
        mode   = 2'b01;
        sh_key = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        if (sh_pulse_o) cnt++;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < LAT + 8; i++) begin
            step();
            if (sh_pulse_o) cnt++;
        end
        sh_key = 1'b0;
        for (int i = 0; i < LAT + 6; i++) begin
            step();
            if (sh_pulse_o) cnt++;
        end
        total++; if (cnt !== 0) begin bad++; $display("FAIL midreset_pulse: got %0d want 0", cnt); end
        total++; if (q !== 8'hFF || q_serial !== 1'b1) begin bad++; $display("FAIL midreset_state: got %h/%b want ff/1", q, q_serial); end
        // A fresh press after release works again
        ds = 1'b0;
        press(1'b1, 1'b1, lat, np);
        total++; if (lat !== LAT || np !== 1) begin bad++; $display("FAIL rearm: got lat=%0d n=%0d want lat=%0d n=1", lat, np, LAT); end
        press(1'b0, 1'b1, lat, np);
        total++; if (q !== 8'hFE || q !== m_store) begin bad++; $display("FAIL rearm_q: got %h want fe (model %h)", q, m_store); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_shift_left();
        test_debounce();
        test_load_shr();
        test_simultaneous();
        test_oe();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_latch_reg
`default_nettype wire
